// File: rtl/mem_arbiter_if.sv
// Request/response bus between the pipeline, the arbiter and the shared SRAM.
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze;
    logic              sram_ce_n;
    logic              sram_we_n;
    logic [ADDR_W-3:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_ce_n, sram_we_n, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_ce_n, sram_we_n, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port SRAM between fetch and MEM stage;
// data accesses win arbitration and freeze the pipeline while outstanding.
module mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SRAM_LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {DATA, INST} owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             data_req;
    logic             unused_addr_lsbs;

    assign data_req         = bus.mem_r_en | bus.mem_w_en;
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

    // Held high even while a data request waits behind an in-flight fetch.
    assign bus.freeze = data_req & ~(state == RESP && owner == DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= DATA;
            cnt            <= '0;
            bus.if_ready   <= 1'b0;
            bus.mem_ready  <= 1'b0;
            bus.if_rdata   <= '0;
            bus.mem_rdata  <= '0;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        state          <= BUSY;
                        owner          <= DATA;
                        cnt            <= CNT_W'(SRAM_LAT - 1);
                        bus.sram_ce_n  <= 1'b0;
                        bus.sram_we_n  <= ~bus.mem_w_en;  // write wins if both enables set
                        bus.sram_addr  <= bus.mem_addr[ADDR_W-1:2];
                        bus.sram_wdata <= bus.mem_wdata;
                    end else if (bus.if_req) begin
                        state          <= BUSY;
                        owner          <= INST;
                        cnt            <= CNT_W'(SRAM_LAT - 1);
                        bus.sram_ce_n  <= 1'b0;
                        bus.sram_we_n  <= 1'b1;
                        bus.sram_addr  <= bus.if_addr[ADDR_W-1:2];
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (bus.sram_we_n) begin
                            if (owner == DATA) bus.mem_rdata <= bus.sram_rdata;
                            else               bus.if_rdata  <= bus.sram_rdata;
                        end
                        if (owner == DATA) bus.mem_ready <= 1'b1;
                        else               bus.if_ready  <= 1'b1;
                        bus.sram_ce_n <= 1'b1;
                        bus.sram_we_n <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.if_ready  <= 1'b0;
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, fixed-latency SRAM between the instruction-fetch stage and the MEM stage of the 5-stage pipeline. Grants one access at a time, counts out the SRAM latency, and returns read data with a one-cycle ready pulse. Drives `freeze` to stall the whole pipeline while a MEM-stage load or store is outstanding, so the control unit's `mem_r_en`/`mem_w_en` feed it directly. The fetch stage stalls itself on `if_req & ~if_ready`.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: byte address width. SRAM is word-addressed with `ADDR_W-2` bits.
- `SRAM_LAT`, 3: SRAM access cycles. Must be ≥1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_rdata`  out  DATA_W  fetched word, valid when `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse for a fetch.
- `mem_r_en`  in  1  MEM-stage load request.
- `mem_w_en`  in  1  MEM-stage store request.
- `mem_addr`  in  ADDR_W  load/store byte address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data, valid when `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse for a load or store.
- `freeze`  out  1  pipeline stall (combinational).
- `sram_ce_n`  out  1  SRAM chip enable, active-low.
- `sram_we_n`  out  1  SRAM write enable, active-low.
- `sram_addr`  out  ADDR_W-2  word address, equal to byte address `[ADDR_W-1:2]`.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data, valid in the last BUSY cycle.

## Operation
- State machine: IDLE → BUSY → RESP → IDLE.
  - Registered `owner` is DATA or INST. Down-counter `cnt` is sized for `SRAM_LAT`.
- IDLE:
  - If `mem_r_en | mem_w_en`: go to BUSY with owner=DATA.
  - Else if `if_req`: go to BUSY with owner=INST.
  - Latch address, write data and direction; load `cnt=SRAM_LAT-1`.
  - Data always wins over fetch, because the MEM stage holds the older instruction.
- If `mem_r_en` and `mem_w_en` are both high, the access is a write.
- BUSY:
  - `sram_ce_n=0`. `sram_addr` and `sram_wdata` come from the latched values.
  - `sram_we_n=0` for the whole access if it is a write, else 1.
  - `cnt` decrements each cycle. In the cycle with `cnt==0`, a read captures `sram_rdata` into the owner's rdata register, and the state goes to RESP.
- RESP:
  - The owner's ready is 1 for exactly this cycle; SRAM is idle.
  - Next state is always IDLE.
  - For a write, `mem_rdata` is unchanged.
- No preemption: an in-flight access always completes.
  - A request dropped mid-access still completes and pulses ready; the requester ignores the pulse.
- Address bits `[1:0]` are ignored.
- `freeze = (mem_r_en | mem_w_en) & ~(state==RESP & owner==DATA)`.
  - It is high from the first cycle a data request appears, including while waiting behind a fetch.

## Timing
- Reset values (applied asynchronously while `rst_n=0`):
  - state=IDLE, `if_ready=0`, `mem_ready=0`, `if_rdata=0`, `mem_rdata=0`.
  - `sram_ce_n=1`, `sram_we_n=1`, `sram_addr=0`, `sram_wdata=0`.
- `freeze` is combinational and follows the request inputs even during reset.
- Reset mid-access aborts the access immediately. No ready pulse is produced, and requests still held after reset release start a fresh arbitration.
- Request seen in IDLE at cycle 0:
  - BUSY in cycles 1..`SRAM_LAT`.
  - Ready in cycle `SRAM_LAT+1`.
  - Next grant is decided in cycle `SRAM_LAT+2`, giving a throughput of one access per `SRAM_LAT+2` cycles.
- All SRAM outputs, both ready signals and both rdata outputs are registered.

## Test plan
All scenarios use `SRAM_LAT=3`, and the bench's SRAM model returns the stored word.
- Fetch `if_addr=0x10`, SRAM[0x4]=0xDEADBEEF → `sram_addr=0x4` and `sram_ce_n=0` in cycles 1–3; `if_ready=1` and `if_rdata=0xDEADBEEF` in cycle 4 only; `freeze=0` throughout.
- Store `mem_addr=0x40`, `mem_wdata=0x12345678` → `sram_we_n=0` and `sram_addr=0x10` in cycles 1–3; `freeze=1` in cycles 0–3 and 0 in cycle 4; `mem_ready=1` in cycle 4; SRAM[0x10]=0x12345678.
- Load 0x100 and fetch 0x20 both at cycle 0 → `mem_ready` in cycle 4 with the load data; `if_ready` in cycle 9; `freeze=1` in cycles 0–3.
- Fetch at cycle 0, load arrives at cycle 1 → `if_ready` in cycle 4; load BUSY in cycles 6–8; `mem_ready` in cycle 9; `freeze=1` in cycles 1–8.
- `mem_r_en=mem_w_en=1` at address 0x8 → the access is a write (`sram_we_n=0`); `mem_rdata` is unchanged after `mem_ready`.
- `rst_n` low in cycle 2 of a load → `sram_ce_n=1` at once and no `mem_ready`; after release with the load held, BUSY restarts and `mem_ready` arrives 4 cycles after the first IDLE cycle.
